// File: rtl/adc_spi_sequencer.sv
// ADC conversion sequencer: restarts the ADC, waits out the conversion, loads the
// shift register and clocks the 10-bit result out to the host over sclk/cs_n.
module adc_spi_sequencer #(
   parameter int CONV_CYCLES = 12,
   parameter int SCLK_DIV    = 2
) (
   input  logic       clk,
   input  logic       restart_n,
   input  logic       start,
   input  logic       scan,
   input  logic       ch_sel,
   input  logic       abort,
   input  logic [9:0] adc_data,
   output logic       adc_restart,
   output logic       adc_channel,
   output logic       sr_parallel_load,
   output logic       sr_clk_edge,
   output logic       sclk,
   output logic       cs_n,
   output logic       busy,
   output logic       done,
   output logic       sample_valid,
   output logic       sample_ch,
   output logic [9:0] sample_data
);

   localparam int CNT_MAX = (CONV_CYCLES > SCLK_DIV) ? CONV_CYCLES : SCLK_DIV;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RESTART = 3'd1,
      CONVERT = 3'd2,
      LOAD    = 3'd3,
      SHIFT   = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic             scan_q, scan_d;
   logic             adc_channel_q, adc_channel_d;
   logic             sclk_q, sclk_d;
   logic             sr_clk_edge_q, sr_clk_edge_d;
   logic             sample_valid_q, sample_valid_d;
   logic             sample_ch_q, sample_ch_d;
   logic [9:0]       sample_data_q, sample_data_d;
   logic             adc_restart_q, adc_restart_d;
   logic             sr_parallel_load_q, sr_parallel_load_d;
   logic             cs_n_q, cs_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bit_d          = bit_q;
      scan_d         = scan_q;
      adc_channel_d  = adc_channel_q;
      sclk_d         = 1'b0;
      sr_clk_edge_d  = 1'b0;
      sample_valid_d = 1'b0;
      sample_ch_d    = sample_ch_q;
      sample_data_d  = sample_data_q;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d       = RESTART;
               scan_d        = scan;
               adc_channel_d = scan ? 1'b0 : ch_sel;
            end
         end
         RESTART: begin
            state_d = CONVERT;
            cnt_d   = '0;
         end
         CONVERT: begin
            if (cnt_q == CONV_LAST) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOAD: begin
            state_d        = SHIFT;
            cnt_d          = '0;
            bit_d          = '0;
            sample_data_d  = adc_data;
            sample_ch_d    = adc_channel_q;
            sample_valid_d = 1'b1;
         end
         SHIFT: begin
            // each bit is SCLK_DIV cycles low followed by SCLK_DIV cycles high
            sclk_d = sclk_q;
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == 4'd9) begin
                     if (scan_q && !adc_channel_q) begin
                        adc_channel_d = 1'b1;
                        state_d       = RESTART;
                     end else begin
                        state_d = DONE;
                     end
                  end else begin
                     bit_d         = bit_q + 4'd1;
                     sr_clk_edge_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // cancel wins over every transition; a sample is only kept if LOAD completed earlier
      if (state_q != IDLE && abort) begin
         state_d        = IDLE;
         cnt_d          = '0;
         bit_d          = '0;
         scan_d         = scan_q;
         adc_channel_d  = adc_channel_q;
         sclk_d         = 1'b0;
         sr_clk_edge_d  = 1'b0;
         sample_valid_d = 1'b0;
         sample_ch_d    = sample_ch_q;
         sample_data_d  = sample_data_q;
      end

      adc_restart_d      = (state_d == RESTART);
      sr_parallel_load_d = (state_d == LOAD);
      cs_n_d             = !((state_d == LOAD) || (state_d == SHIFT));
      busy_d             = (state_d != IDLE);
      done_d             = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge restart_n) begin
      if (!restart_n) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         bit_q              <= '0;
         scan_q             <= 1'b0;
         adc_channel_q      <= 1'b0;
         sclk_q             <= 1'b0;
         sr_clk_edge_q      <= 1'b0;
         sample_valid_q     <= 1'b0;
         sample_ch_q        <= 1'b0;
         sample_data_q      <= 10'h000;
         adc_restart_q      <= 1'b0;
         sr_parallel_load_q <= 1'b0;
         cs_n_q             <= 1'b1;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         bit_q              <= bit_d;
         scan_q             <= scan_d;
         adc_channel_q      <= adc_channel_d;
         sclk_q             <= sclk_d;
         sr_clk_edge_q      <= sr_clk_edge_d;
         sample_valid_q     <= sample_valid_d;
         sample_ch_q        <= sample_ch_d;
         sample_data_q      <= sample_data_d;
         adc_restart_q      <= adc_restart_d;
         sr_parallel_load_q <= sr_parallel_load_d;
         cs_n_q             <= cs_n_d;
         busy_q             <= busy_d;
         done_q             <= done_d;
      end
   end

   assign adc_restart      = adc_restart_q;
   assign adc_channel      = adc_channel_q;
   assign sr_parallel_load = sr_parallel_load_q;
   assign sr_clk_edge      = sr_clk_edge_q;
   assign sclk             = sclk_q;
   assign cs_n             = cs_n_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign sample_valid     = sample_valid_q;
   assign sample_ch        = sample_ch_q;
   assign sample_data      = sample_data_q;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Bench for adc_spi_sequencer: default instance plus a fast SCLK_DIV=1/CONV_CYCLES=1 instance,
// with a sample scoreboard and pulse/latency counters.
module tb_adc_spi_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       restart_n, start, scan, ch_sel, abort;
   logic [9:0] val0, val1, adc_data;
   logic       adc_restart, adc_channel, sr_parallel_load, sr_clk_edge, sclk, cs_n;
   logic       busy, done, sample_valid, sample_ch;
   logic [9:0] sample_data;

   logic       start_f;
   logic [9:0] adc_data_f;
   logic       adc_restart_f, adc_channel_f, sr_parallel_load_f, sr_clk_edge_f, sclk_f, cs_n_f;
   logic       busy_f, done_f, sample_valid_f, sample_ch_f;
   logic [9:0] sample_data_f;

   assign adc_data = adc_channel ? val1 : val0;

   adc_spi_sequencer dut (
      .clk(clk), .restart_n(restart_n), .start(start), .scan(scan), .ch_sel(ch_sel),
      .abort(abort), .adc_data(adc_data), .adc_restart(adc_restart),
      .adc_channel(adc_channel), .sr_parallel_load(sr_parallel_load),
      .sr_clk_edge(sr_clk_edge), .sclk(sclk), .cs_n(cs_n), .busy(busy), .done(done),
      .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data)
   );

   adc_spi_sequencer #(.CONV_CYCLES(1), .SCLK_DIV(1)) dut_fast (
      .clk(clk), .restart_n(restart_n), .start(start_f), .scan(scan), .ch_sel(ch_sel),
      .abort(abort), .adc_data(adc_data_f), .adc_restart(adc_restart_f),
      .adc_channel(adc_channel_f), .sr_parallel_load(sr_parallel_load_f),
      .sr_clk_edge(sr_clk_edge_f), .sclk(sclk_f), .cs_n(cs_n_f), .busy(busy_f), .done(done_f),
      .sample_valid(sample_valid_f), .sample_ch(sample_ch_f), .sample_data(sample_data_f)
   );

   int nchk = 0;
   int nfail = 0;

   task automatic check(input string tag, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_restart = 0, n_load = 0, n_edge = 0, n_rise = 0, n_done = 0, n_valid = 0;
   int done_cyc = -1000, load_cyc = -1000;
   int f_rise = 0, f_high = 0, f_done = 0, f_done_cyc = -1000;
   logic sclk_prev = 1'b0, sclk_f_prev = 1'b0;
   logic [10:0] exp_q[$];
   logic [10:0] exp_s;

   always @(negedge clk) begin
      if (adc_restart) n_restart++;
      if (sr_parallel_load) begin n_load++; load_cyc = cyc; end
      if (sr_clk_edge) n_edge++;
      if (sclk && !sclk_prev) n_rise++;
      sclk_prev = sclk;
      if (done) begin n_done++; done_cyc = cyc; end
      if (sample_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            check("sb_unexpected_sample", exp_q.size(), 1);
         end else begin
            exp_s = exp_q.pop_front();
            check("sb_sample", int'({sample_ch, sample_data}), int'(exp_s));
         end
      end
      if (sclk_f && !sclk_f_prev) f_rise++;
      if (sclk_f) f_high++;
      sclk_f_prev = sclk_f;
      if (done_f) begin f_done++; f_done_cyc = cyc; end
   end

   int b_restart, b_edge, b_rise, b_done, b_valid;

   task automatic snap();
      b_restart = n_restart; b_edge = n_edge; b_rise = n_rise;
      b_done = n_done; b_valid = n_valid;
   endtask

   function automatic logic [19:0] out_vec();
      return {adc_restart, adc_channel, sr_parallel_load, sr_clk_edge, sclk, cs_n,
              busy, done, sample_valid, sample_ch, sample_data};
   endfunction

   logic [19:0] rst_exp;

   task automatic pulse_start(input logic sc, input logic cs, output int s);
      @(posedge clk); #1;
      scan = sc; ch_sel = cs; start = 1'b1; s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic frame_checks(input int s, input int lat, input int n);
      check("done_latency", done_cyc - s, lat);
      check("done_count", n_done - b_done, 1);
      check("restart_pulses", n_restart - b_restart, n);
      check("sr_clk_edge_pulses", n_edge - b_edge, 9 * n);
      check("sclk_periods", n_rise - b_rise, 10 * n);
      check("sample_valid_pulses", n_valid - b_valid, n);
      check("sb_drained", exp_q.size(), 0);
   endtask

   int s, k, fs;

   initial begin
      rst_exp = {5'b00000, 1'b1, 4'b0000, 10'h000};
      restart_n = 1'b0; start = 1'b0; scan = 1'b0; ch_sel = 1'b0; abort = 1'b0;
      val0 = 10'h000; val1 = 10'h000; start_f = 1'b0; adc_data_f = 10'h1A5;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", int'(out_vec()), int'(rst_exp));
      check("reset_fast_cs_busy", int'({cs_n_f, busy_f, sclk_f}), 4);
      @(negedge clk) restart_n = 1'b1;

      // single conversion, channel 0
      val0 = 10'h3FF;
      exp_q.push_back({1'b0, 10'h3FF});
      snap();
      pulse_start(1'b0, 1'b0, s);
      repeat (70) @(posedge clk);
      #1;
      frame_checks(s, 55, 1);
      check("load_after_convert", load_cyc - s, 14);
      check("idle_after_single", int'({busy, cs_n, sclk}), 2);

      // scan: channel 0 then channel 1
      val0 = 10'h000; val1 = 10'h2AA;
      exp_q.push_back({1'b0, 10'h000});
      exp_q.push_back({1'b1, 10'h2AA});
      snap();
      pulse_start(1'b1, 1'b1, s);
      repeat (125) @(posedge clk);
      #1;
      frame_checks(s, 109, 2);

      // second start during CONVERT is dropped
      val0 = 10'h3C3;
      exp_q.push_back({1'b0, 10'h3C3});
      snap();
      pulse_start(1'b0, 1'b0, s);
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (70) @(posedge clk);
      #1;
      frame_checks(s, 55, 1);

      // abort in SHIFT after four sr_clk_edge pulses
      val0 = 10'h0F0;
      exp_q.push_back({1'b0, 10'h0F0});
      snap();
      pulse_start(1'b0, 1'b0, s);
      k = 0;
      while ((n_edge - b_edge) < 4 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("abort_reached_4_edges", n_edge - b_edge, 4);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_idle_outputs", int'({busy, cs_n, sclk, sr_parallel_load, sr_clk_edge, done}), 16);
      repeat (70) @(posedge clk);
      #1;
      check("abort_no_done", n_done - b_done, 0);
      check("abort_no_more_edges", n_edge - b_edge, 4);
      check("abort_sample_kept", int'(sample_data), 10'h0F0);
      check("abort_sb_drained", exp_q.size(), 0);

      // asynchronous reset while converting, then a normal channel 1 request
      val1 = 10'h155;
      pulse_start(1'b0, 1'b1, s);
      repeat (5) @(posedge clk);
      #3 restart_n = 1'b0;
      #1;
      check("async_reset_outputs", int'(out_vec()), int'(rst_exp));
      @(negedge clk) restart_n = 1'b1;
      exp_q.push_back({1'b1, 10'h155});
      snap();
      pulse_start(1'b0, 1'b1, s);
      repeat (70) @(posedge clk);
      #1;
      frame_checks(s, 55, 1);
      check("ch1_sample_ch", int'(sample_ch), 1);

      // fast instance: sclk toggles every cycle
      scan = 1'b0; ch_sel = 1'b0;
      k = f_rise; s = f_high; fs = f_done;
      @(posedge clk);
      #1 start_f = 1'b1;
      b_done = cyc;
      @(posedge clk);
      #1 start_f = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("fast_done_latency", f_done_cyc - b_done, 24);
      check("fast_done_count", f_done - fs, 1);
      check("fast_sclk_rises", f_rise - k, 10);
      check("fast_sclk_high_cycles", f_high - s, 10);
      check("fast_sample", int'({sample_ch_f, sample_data_f}), 11'h1A5);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/adc_spi_sequencer.md
ADC_SPI_SEQUENCER -- requirements
Module: adc_spi_sequencer

Interface
REQ-001 Parameters SHALL be: CONV_CYCLES, default 12, clocks to wait after adc_restart deasserts; SCLK_DIV, default 2, clocks per sclk half-period (min 1).
REQ-002 Ports SHALL be:
- clk  in  1  system clock; all state changes on rising edge.
- restart_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle conversion request; sampled only in IDLE.
- scan  in  1  0 = convert ch_sel only; 1 = convert channel 0 then channel 1.
- ch_sel  in  1  channel for single mode.
- abort  in  1  synchronous cancel.
- adc_data  in  10  ADC register_out value.
- adc_restart  out  1  ADC restart strobe.
- adc_channel  out  1  ADC channel select.
- sr_parallel_load  out  1  shift-register parallelLoad.
- sr_clk_edge  out  1  shift-register peripheralClkEdge (one-cycle pulse).
- sclk  out  1  serial clock to host.
- cs_n  out  1  active-low frame select to host.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at end of a start request.
- sample_valid  out  1  one-cycle pulse when sample_data updates.
- sample_ch  out  1  channel of sample_data.
- sample_data  out  10  copy of adc_data captured at LOAD.

Function
REQ-003 The FSM SHALL have states IDLE, RESTART, CONVERT, LOAD, SHIFT, DONE.
REQ-004 IDLE -> RESTART when start=1; adc_channel SHALL be set to ch_sel (scan=0) or 0 (scan=1) on that edge, and scan/ch_sel SHALL be latched for the whole request.
REQ-005 RESTART SHALL last exactly 1 cycle with adc_restart=1; adc_restart SHALL be 0 in all other states.
REQ-006 CONVERT SHALL last exactly CONV_CYCLES cycles, then go to LOAD.
REQ-007 LOAD SHALL last 1 cycle with sr_parallel_load=1 and cs_n=0; on that edge sample_data<=adc_data, sample_ch<=adc_channel, and sample_valid pulses in the following cycle.
REQ-008 SHIFT SHALL last 10*2*SCLK_DIV cycles: per bit, sclk low SCLK_DIV cycles then high SCLK_DIV cycles; cs_n=0 throughout.
REQ-009 sr_clk_edge SHALL pulse for one cycle on each sclk high-to-low transition of bits 0..8 (9 pulses per frame); no pulse after bit 9.
REQ-010 After SHIFT: if scan latched 1 and adc_channel=0, adc_channel<=1 and go to RESTART; else go to DONE.
REQ-011 DONE SHALL last 1 cycle with done=1, cs_n=1, then IDLE.
REQ-012 start while busy=1 SHALL be ignored (not queued).
REQ-013 abort=1 in any non-IDLE state SHALL force IDLE next edge: cs_n=1, sclk=0, sr_* =0, no done pulse, sample_data unchanged unless LOAD already occurred; abort has priority over every other transition.
REQ-014 start and abort high together in IDLE SHALL leave the block in IDLE.
REQ-015 Single-mode latency: done SHALL assert 3+CONV_CYCLES+20*SCLK_DIV cycles after the start edge (55 at defaults); scan mode adds 2+CONV_CYCLES+20*SCLK_DIV (54 at defaults).
REQ-016 Outputs SHALL be registered; sclk SHALL be 0 and cs_n 1 outside LOAD/SHIFT.

Reset
REQ-017 restart_n=0 SHALL asynchronously force IDLE with adc_restart=0, adc_channel=0, sr_parallel_load=0, sr_clk_edge=0, sclk=0, cs_n=1, busy=0, done=0, sample_valid=0, sample_ch=0, sample_data=10'h000, all counters 0.
REQ-018 Reset asserted mid-frame SHALL abandon the frame; first start after release SHALL run a full sequence.

Verification
REQ-019 Single ch0: scan=0, ch_sel=0, adc_data=10'h3FF, start pulse -> one adc_restart pulse, sr_parallel_load after 12 CONVERT cycles, sample_data=10'h3FF, sample_ch=0, 9 sr_clk_edge pulses, 10 sclk periods, done 55 cycles after start.
REQ-020 Scan: scan=1, adc_data=10'h000 for ch0 then 10'h2AA for ch1 -> two frames, adc_channel 0 then 1, two sample_valid pulses (000/ch0, 2AA/ch1), single done 109 cycles after start.
REQ-021 Busy rejection: second start 5 cycles into CONVERT -> ignored, exactly one frame, one done.
REQ-022 Abort in SHIFT after 4 sr_clk_edge pulses -> IDLE next cycle, cs_n=1, sclk=0, no done, no further edges.
REQ-023 Async reset: restart_n low mid-CONVERT between clock edges -> outputs reach REQ-017 values before next clk edge; new start runs normally.
REQ-024 Parameter sweep: SCLK_DIV=1, CONV_CYCLES=1 -> sclk toggles every cycle, done 24 cycles after start.
